clk_div_monitor: RTL and testbench

Reference-clock-domain checker for the programmable divided clock. It samples the divided clock as data, measures period and high time in reference cycles, and compares them with the programmed ratio. It reports per-period measurements, a lock indication and error flags for DFT/bring-up status registers.

---
 rtl/clk_div_mon_pkg.sv | 10 +
 rtl/clk_div_monitor_if.sv | 23 ++
 rtl/clk_div_mon_sync.sv | 22 ++
 rtl/clk_div_monitor.sv | 129 ++++++++++++
 tb/tb_clk_div_monitor.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_mon_pkg.sv
// clk_div_mon_pkg: shared FSM state encoding and synchronizer depth for the divided-clock monitor
package clk_div_mon_pkg;
    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;
    localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/clk_div_monitor_if.sv
// clk_div_monitor_if: control and status bundle of the divided-clock monitor
interface clk_div_monitor_if #(
    parameter int DIV_RATIO_WIDTH = 8
);
    logic                       i_en;
    logic [DIV_RATIO_WIDTH-1:0] i_div_ratio;
    logic                       i_div_clk;
    logic                       i_err_clr;
    logic                       o_meas_valid;
    logic [DIV_RATIO_WIDTH:0]   o_period;
    logic [DIV_RATIO_WIDTH:0]   o_high;
    logic                       o_lock;
    logic                       o_err;
    logic                       o_err_sticky;
    modport master (
        output i_en, i_div_ratio, i_div_clk, i_err_clr,
        input  o_meas_valid, o_period, o_high, o_lock, o_err, o_err_sticky
    );
    modport slave (
        input  i_en, i_div_ratio, i_div_clk, i_err_clr,
        output o_meas_valid, o_period, o_high, o_lock, o_err, o_err_sticky
    );
endinterface

// File: rtl/clk_div_mon_sync.sv
// clk_div_mon_sync: bit synchronizer plus one history flop so the caller can detect edges
module clk_div_mon_sync
    import clk_div_mon_pkg::*;
(
    input  logic i_ref_clk,
    input  logic i_rst_n,
    input  logic d,
    output logic s,
    output logic s_d
);
    logic [SYNC_DEPTH-1:0] sr;
    always_ff @(posedge i_ref_clk) begin
        if (!i_rst_n) begin
            sr  <= '0;
            s_d <= 1'b0;
        end else begin
            sr  <= {sr[SYNC_DEPTH-2:0], d};
            s_d <= sr[SYNC_DEPTH-1];
        end
    end
    assign s = sr[SYNC_DEPTH-1];
endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures a divided clock in reference cycles and checks period/duty against the programmed ratio
module clk_div_monitor
    import clk_div_mon_pkg::*;
#(
    parameter int DIV_RATIO_WIDTH = 8,
    parameter int LOCK_PERIODS    = 4
) (
    input logic              i_ref_clk,
    input logic              i_rst_n,
    clk_div_monitor_if.slave bus
);
    localparam int CW = DIV_RATIO_WIDTH + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [3:0] LOCK_N = 4'(LOCK_PERIODS);
    state_t state, state_d;
    logic s, s_d, rise, fall, active, ratio_chg, good_per;
    logic lock_d, valid_d, err_d;
    logic [DIV_RATIO_WIDTH-1:0] ratio_q;
    logic [CW-1:0] cnt, cnt_d, cnt_inc, high_q, high_q_d, period_d, high_d, n, n_lo, n_hi;
    logic [3:0] good, good_d;
    clk_div_mon_sync u_sync (
        .i_ref_clk(i_ref_clk),
        .i_rst_n  (i_rst_n),
        .d        (bus.i_div_clk),
        .s        (s),
        .s_d      (s_d)
    );
    assign rise      = s & ~s_d;
    assign fall      = ~s & s_d;
    assign active    = bus.i_en && (bus.i_div_ratio >= DIV_RATIO_WIDTH'(2));
    assign ratio_chg = bus.i_div_ratio != ratio_q;
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign n         = CW'(ratio_q);
    assign n_lo      = n >> 1;
    assign n_hi      = (n + 1'b1) >> 1;
    assign good_per  = (cnt == n) && ((high_q == n_lo) || (high_q == n_hi));
    // Timeout and bad periods share the error path; only timeout abandons the measurement.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt_inc;
        high_q_d = high_q;
        good_d   = good;
        lock_d   = bus.o_lock;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        period_d = bus.o_period;
        high_d   = bus.o_high;
        if (!active) begin
            state_d  = IDLE;
            cnt_d    = '0;
            high_q_d = '0;
            good_d   = '0;
            lock_d   = 1'b0;
        end else if (ratio_chg) begin
            state_d = WAIT_RISE;
            cnt_d   = '0;
            good_d  = '0;
            lock_d  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_d = WAIT_RISE;
                    cnt_d   = '0;
                end
                WAIT_RISE: begin
                    cnt_d   = rise ? CW'(1) : '0;
                    state_d = rise ? MEAS_HIGH : WAIT_RISE;
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        high_q_d = cnt;
                        state_d  = MEAS_LOW;
                    end else if (cnt == CNT_MAX) begin
                        err_d   = 1'b1;
                        lock_d  = 1'b0;
                        good_d  = '0;
                        cnt_d   = '0;
                        state_d = WAIT_RISE;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        valid_d  = 1'b1;
                        period_d = cnt;
                        high_d   = high_q;
                        cnt_d    = CW'(1);
                        state_d  = MEAS_HIGH;
                        good_d   = good_per ? ((good == LOCK_N) ? good : good + 1'b1) : '0;
                        lock_d   = good_per && (good_d == LOCK_N);
                        err_d    = !good_per;
                    end else if (cnt == CNT_MAX) begin
                        err_d   = 1'b1;
                        lock_d  = 1'b0;
                        good_d  = '0;
                        cnt_d   = '0;
                        state_d = WAIT_RISE;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge i_ref_clk) begin
        if (!i_rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            high_q           <= '0;
            good             <= '0;
            ratio_q          <= '0;
            bus.o_meas_valid <= 1'b0;
            bus.o_period     <= '0;
            bus.o_high       <= '0;
            bus.o_lock       <= 1'b0;
            bus.o_err        <= 1'b0;
            bus.o_err_sticky <= 1'b0;
        end else begin
            state            <= state_d;
            cnt              <= cnt_d;
            high_q           <= high_q_d;
            good             <= good_d;
            ratio_q          <= bus.i_div_ratio;
            bus.o_meas_valid <= valid_d;
            bus.o_period     <= period_d;
            bus.o_high       <= high_d;
            bus.o_lock       <= lock_d;
            bus.o_err        <= err_d;
            bus.o_err_sticky <= err_d | (bus.o_err_sticky & ~bus.i_err_clr);
        end
    end
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: directed checks of the divided-clock monitor
module tb_clk_div_monitor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0, errors = 0, cyc = 0, err_cnt = 0, err_cyc = 0;
    logic sticky_at_err = 1'b0;
    int q_per[$], q_high[$], q_lock[$], q_cyc[$];
    clk_div_monitor_if #(.DIV_RATIO_WIDTH(8)) bus ();
    clk_div_monitor #(.DIV_RATIO_WIDTH(8), .LOCK_PERIODS(4)) dut (
        .i_ref_clk(clk),
        .i_rst_n  (rst_n),
        .bus      (bus.slave)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.o_meas_valid) begin
            q_per.push_back(int'(bus.o_period));
            q_high.push_back(int'(bus.o_high));
            q_lock.push_back(int'(bus.o_lock));
            q_cyc.push_back(cyc);
        end
        if (bus.o_err) begin
            err_cnt++;
            err_cyc = cyc;
            sticky_at_err = bus.o_err_sticky;
        end
    endtask
    task automatic clear_obs();
        q_per.delete();
        q_high.delete();
        q_lock.delete();
        q_cyc.delete();
        err_cnt = 0;
    endtask
    task automatic gen(input int h, input int l, input int p);
        for (int k = 0; k < p; k++) begin
            repeat (h) begin bus.i_div_clk = 1'b1; step(); end
            repeat (l) begin bus.i_div_clk = 1'b0; step(); end
        end
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_en = 1'b0;
        bus.i_div_ratio = '0;
        bus.i_div_clk = 1'b0;
        bus.i_err_clr = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        clear_obs();
    endtask
    task automatic start(input int n);
        bus.i_en = 1'b1;
        bus.i_div_ratio = 8'(n);
        repeat (4) step();
    endtask
    task automatic test_reset();
        do_reset();
        step();
        vectors++;
        if ({bus.o_meas_valid, bus.o_lock, bus.o_err, bus.o_err_sticky} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {bus.o_meas_valid, bus.o_lock, bus.o_err, bus.o_err_sticky});
        end
        vectors++;
        if ({bus.o_period, bus.o_high} !== 18'd0) begin
            errors++;
            $display("FAIL reset_meas: period %0d high %0d expected 0 0", bus.o_period, bus.o_high);
        end
    endtask
    task automatic test_n4();
        do_reset();
        start(4);
        gen(2, 2, 8);
        repeat (6) step();
        vectors++;
        if (q_per.size() != 7) begin
            errors++;
            $display("FAIL n4_count: got %0d valids expected 7", q_per.size());
        end
        for (int i = 0; i < q_per.size(); i++) begin
            vectors++;
            if (q_per[i] !== 4 || q_high[i] !== 2) begin
                errors++;
                $display("FAIL n4_meas[%0d]: got %0d/%0d expected 4/2", i, q_per[i], q_high[i]);
            end
            vectors++;
            if (q_lock[i] !== int'(i >= 3)) begin
                errors++;
                $display("FAIL n4_lock[%0d]: got %0d expected %0d", i, q_lock[i], int'(i >= 3));
            end
            if (i > 0) begin
                vectors++;
                if (q_cyc[i] - q_cyc[i-1] !== 4) begin
                    errors++;
                    $display("FAIL n4_spacing[%0d]: got %0d expected 4", i, q_cyc[i] - q_cyc[i-1]);
                end
            end
        end
        vectors++;
        if (err_cnt !== 0) begin
            errors++;
            $display("FAIL n4_err: got %0d pulses expected 0", err_cnt);
        end
    endtask
    task automatic test_n5_bad_period();
        int ep, eh, el;
        do_reset();
        start(5);
        gen(2, 3, 6);
        gen(3, 3, 1);
        gen(2, 3, 6);
        repeat (6) step();
        vectors++;
        if (q_per.size() != 12) begin
            errors++;
            $display("FAIL n5_count: got %0d valids expected 12", q_per.size());
        end
        for (int i = 0; i < q_per.size(); i++) begin
            ep = (i == 6) ? 6 : 5;
            eh = (i == 6) ? 3 : 2;
            el = int'((i >= 3 && i <= 5) || i >= 10);
            vectors++;
            if (q_per[i] !== ep || q_high[i] !== eh || q_lock[i] !== el) begin
                errors++;
                $display("FAIL n5_valid[%0d]: got %0d/%0d lock %0d expected %0d/%0d lock %0d", i, q_per[i], q_high[i], q_lock[i], ep, eh, el);
            end
        end
        vectors++;
        if (err_cnt !== 1) begin
            errors++;
            $display("FAIL n5_err_pulses: got %0d expected 1", err_cnt);
        end
        if (q_cyc.size() > 6) begin
            vectors++;
            if (err_cyc !== q_cyc[6]) begin
                errors++;
                $display("FAIL n5_err_time: got cycle %0d expected %0d", err_cyc, q_cyc[6]);
            end
        end
        vectors++;
        if (bus.o_err_sticky !== 1'b1 || bus.o_lock !== 1'b1) begin
            errors++;
            $display("FAIL n5_final: sticky %b lock %b expected 1 1", bus.o_err_sticky, bus.o_lock);
        end
        bus.i_err_clr = 1'b1;
        step();
        bus.i_err_clr = 1'b0;
        vectors++;
        if (bus.o_err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear: got %b expected 0", bus.o_err_sticky);
        end
    endtask
    task automatic test_n2();
        do_reset();
        start(2);
        gen(1, 1, 8);
        repeat (6) step();
        vectors++;
        if (q_per.size() != 7) begin
            errors++;
            $display("FAIL n2_count: got %0d valids expected 7", q_per.size());
        end
        for (int i = 0; i < q_per.size(); i++) begin
            vectors++;
            if (q_per[i] !== 2 || q_high[i] !== 1 || q_lock[i] !== int'(i >= 3)) begin
                errors++;
                $display("FAIL n2_valid[%0d]: got %0d/%0d lock %0d expected 2/1 lock %0d", i, q_per[i], q_high[i], q_lock[i], int'(i >= 3));
            end
        end
        vectors++;
        if (err_cnt !== 0) begin
            errors++;
            $display("FAIL n2_err: got %0d pulses expected 0", err_cnt);
        end
    endtask
    task automatic test_timeout();
        int c0;
        bit seen;
        do_reset();
        start(8);
        c0 = cyc;
        seen = 1'b0;
        gen(4, 4, 6);
        vectors++;
        if (bus.o_lock !== 1'b1 || q_per.size() != 5) begin
            errors++;
            $display("FAIL to_prelock: lock %b valids %0d expected 1 5", bus.o_lock, q_per.size());
        end
        for (int i = 0; i < 700 && !seen; i++) begin
            step();
            seen = err_cnt != 0;
        end
        vectors++;
        if (!seen) begin
            errors++;
            $display("FAIL to_wait: no error pulse within 700 cycles, expected one");
        end else if (err_cyc !== c0 + 554) begin
            errors++;
            $display("FAIL to_time: error at cycle %0d expected %0d", err_cyc - c0, 554);
        end
        vectors++;
        if (bus.o_lock !== 1'b0 || bus.o_err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL to_state: lock %b sticky %b expected 0 1", bus.o_lock, bus.o_err_sticky);
        end
    endtask
    task automatic test_ratio_change();
        do_reset();
        start(4);
        gen(2, 2, 6);
        repeat (6) step();
        vectors++;
        if (bus.o_lock !== 1'b1) begin
            errors++;
            $display("FAIL rc_prelock: got %b expected 1", bus.o_lock);
        end
        clear_obs();
        bus.i_div_ratio = 8'd6;
        step();
        vectors++;
        if (bus.o_lock !== 1'b0 || bus.o_err !== 1'b0) begin
            errors++;
            $display("FAIL rc_drop: lock %b err %b expected 0 0", bus.o_lock, bus.o_err);
        end
        repeat (3) step();
        gen(3, 3, 7);
        repeat (6) step();
        vectors++;
        if (q_per.size() != 6 || err_cnt !== 0) begin
            errors++;
            $display("FAIL rc_count: valids %0d errs %0d expected 6 0", q_per.size(), err_cnt);
        end
        for (int i = 0; i < q_per.size(); i++) begin
            vectors++;
            if (q_per[i] !== 6 || q_high[i] !== 3 || q_lock[i] !== int'(i >= 3)) begin
                errors++;
                $display("FAIL rc_valid[%0d]: got %0d/%0d lock %0d expected 6/3 lock %0d", i, q_per[i], q_high[i], q_lock[i], int'(i >= 3));
            end
        end
    endtask
    task automatic test_inactive();
        do_reset();
        start(0);
        gen(2, 2, 6);
        bus.i_en = 1'b0;
        bus.i_div_ratio = 8'd4;
        gen(2, 2, 6);
        repeat (4) step();
        vectors++;
        if (q_per.size() != 0 || err_cnt !== 0) begin
            errors++;
            $display("FAIL inactive_events: valids %0d errs %0d expected 0 0", q_per.size(), err_cnt);
        end
        vectors++;
        if ({bus.o_period, bus.o_high} !== 18'd0 || {bus.o_lock, bus.o_err_sticky} !== 2'b00) begin
            errors++;
            $display("FAIL inactive_outs: period %0d high %0d lock %b sticky %b expected 0 0 0 0", bus.o_period, bus.o_high, bus.o_lock, bus.o_err_sticky);
        end
    endtask
    task automatic test_mid_reset();
        do_reset();
        start(4);
        gen(2, 2, 5);
        gen(3, 1, 1);
        gen(2, 2, 2);
        repeat (6) step();
        vectors++;
        if (bus.o_err_sticky !== 1'b1 || bus.o_period !== 9'd4 || bus.o_high !== 9'd2 || err_cnt !== 1) begin
            errors++;
            $display("FAIL mr_pre: sticky %b period %0d high %0d errs %0d expected 1 4 2 1", bus.o_err_sticky, bus.o_period, bus.o_high, err_cnt);
        end
        gen(2, 1, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        vectors++;
        if ({bus.o_meas_valid, bus.o_lock, bus.o_err, bus.o_err_sticky} !== 4'b0 || {bus.o_period, bus.o_high} !== 18'd0) begin
            errors++;
            $display("FAIL mr_post: flags %b period %0d high %0d expected 0000 0 0", {bus.o_meas_valid, bus.o_lock, bus.o_err, bus.o_err_sticky}, bus.o_period, bus.o_high);
        end
    endtask
    task automatic test_clr_collision();
        do_reset();
        bus.i_err_clr = 1'b1;
        start(4);
        gen(2, 2, 3);
        gen(3, 3, 1);
        gen(2, 2, 2);
        repeat (6) step();
        vectors++;
        if (err_cnt !== 1 || sticky_at_err !== 1'b1) begin
            errors++;
            $display("FAIL clr_collision: errs %0d sticky-at-err %b expected 1 1", err_cnt, sticky_at_err);
        end
        vectors++;
        if (bus.o_err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL clr_after: got %b expected 0", bus.o_err_sticky);
        end
        bus.i_err_clr = 1'b0;
    endtask
    initial begin
        test_reset();
        test_n4();
        test_n5_bad_period();
        test_n2();
        test_timeout();
        test_ratio_change();
        test_inactive();
        test_mid_reset();
        test_clr_collision();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
